// File: rtl/stopwatch_bcd.sv
// BCD stopwatch: counts 1/100 s ticks into MM:SS.hh with start/stop and lap/clear
// pushbuttons, and shows either the live count or a frozen lap snapshot.
module stopwatch_bcd #(
  parameter int unsigned MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsec_tick,
  input  logic       start_stop_n,
  input  logic       lap_clr_n,
  output logic [7:0] hsec_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       running,
  output logic       lap,
  output logic       rollover
);

  localparam logic [7:0] MIN_LAST = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

  state_t     r_state;
  logic       r_ss_meta, r_ss_sync, r_ss_hist;
  logic       r_lc_meta, r_lc_sync, r_lc_hist;
  logic [7:0] r_cnt_min, r_cnt_sec, r_cnt_hsec;
  logic [7:0] r_lap_min, r_lap_sec, r_lap_hsec;
  logic       r_running, r_lap, r_rollover;

  logic       w_ss_press, w_lc_press, w_en, w_wrap;
  logic [7:0] w_nxt_min, w_nxt_sec, w_nxt_hsec;

  // Synchronizer and history flops idle high so reset release is never a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_meta <= 1'b1;
      r_ss_sync <= 1'b1;
      r_ss_hist <= 1'b1;
      r_lc_meta <= 1'b1;
      r_lc_sync <= 1'b1;
      r_lc_hist <= 1'b1;
    end else begin
      r_ss_meta <= start_stop_n;
      r_ss_sync <= r_ss_meta;
      r_ss_hist <= r_ss_sync;
      r_lc_meta <= lap_clr_n;
      r_lc_sync <= r_lc_meta;
      r_lc_hist <= r_lc_sync;
    end
  end

  assign w_ss_press = r_ss_hist & ~r_ss_sync;
  assign w_lc_press = r_lc_hist & ~r_lc_sync;
  assign w_en       = hsec_tick && (r_state == RUN || r_state == LAP);

  always_comb begin
    w_nxt_hsec = r_cnt_hsec;
    w_nxt_sec  = r_cnt_sec;
    w_nxt_min  = r_cnt_min;
    w_wrap     = 1'b0;
    if (w_en) begin
      if (r_cnt_hsec[3:0] != 4'd9) begin
        w_nxt_hsec[3:0] = r_cnt_hsec[3:0] + 4'd1;
      end else begin
        w_nxt_hsec[3:0] = '0;
        if (r_cnt_hsec[7:4] != 4'd9) begin
          w_nxt_hsec[7:4] = r_cnt_hsec[7:4] + 4'd1;
        end else begin
          w_nxt_hsec[7:4] = '0;
          if (r_cnt_sec[3:0] != 4'd9) begin
            w_nxt_sec[3:0] = r_cnt_sec[3:0] + 4'd1;
          end else begin
            w_nxt_sec[3:0] = '0;
            if (r_cnt_sec[7:4] != 4'd5) begin
              w_nxt_sec[7:4] = r_cnt_sec[7:4] + 4'd1;
            end else begin
              w_nxt_sec[7:4] = '0;
              if (r_cnt_min == MIN_LAST) begin
                w_nxt_min = '0;
                w_wrap    = 1'b1;
              end else if (r_cnt_min[3:0] != 4'd9) begin
                w_nxt_min[3:0] = r_cnt_min[3:0] + 4'd1;
              end else begin
                w_nxt_min[3:0] = '0;
                w_nxt_min[7:4] = r_cnt_min[7:4] + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  // Start press is tested first so it wins over a simultaneous lap press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt_min  <= '0;
      r_cnt_sec  <= '0;
      r_cnt_hsec <= '0;
      r_lap_min  <= '0;
      r_lap_sec  <= '0;
      r_lap_hsec <= '0;
      r_running  <= 1'b0;
      r_lap      <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_cnt_min  <= w_nxt_min;
      r_cnt_sec  <= w_nxt_sec;
      r_cnt_hsec <= w_nxt_hsec;
      r_rollover <= w_wrap;
      case (r_state)
        IDLE: begin
          if (w_ss_press) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (w_ss_press) begin
            r_state   <= STOP;
            r_running <= 1'b0;
          end else if (w_lc_press) begin
            r_state    <= LAP;
            r_lap      <= 1'b1;
            r_lap_min  <= w_nxt_min;
            r_lap_sec  <= w_nxt_sec;
            r_lap_hsec <= w_nxt_hsec;
          end
        end
        LAP: begin
          if (w_ss_press) begin
            r_state   <= STOP;
            r_running <= 1'b0;
            r_lap     <= 1'b0;
          end else if (w_lc_press) begin
            r_state <= RUN;
            r_lap   <= 1'b0;
          end
        end
        STOP: begin
          if (w_ss_press) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else if (w_lc_press) begin
            r_state    <= IDLE;
            r_cnt_min  <= '0;
            r_cnt_sec  <= '0;
            r_cnt_hsec <= '0;
            r_lap_min  <= '0;
            r_lap_sec  <= '0;
            r_lap_hsec <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
          r_lap     <= 1'b0;
        end
      endcase
    end
  end

  assign hsec_bcd = r_lap ? r_lap_hsec : r_cnt_hsec;
  assign sec_bcd  = r_lap ? r_lap_sec  : r_cnt_sec;
  assign min_bcd  = r_lap ? r_lap_min  : r_cnt_min;
  assign running  = r_running;
  assign lap      = r_lap;
  assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: directed vector table, hand sequences for rollover and
// async reset, and random stimulus checked against a total-hundredths model.
module tb_stopwatch_bcd;

  // Small minutes limit keeps the wrap reachable in a short run.
  localparam int MM   = 3;
  localparam int MAXT = (MM + 1) * 6000;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;

  logic       clk, rst_n, hsec_tick, start_stop_n, lap_clr_n;
  logic [7:0] hsec_bcd, sec_bcd, min_bcd;
  logic       running, lap, rollover;

  int errors = 0;
  int checks = 0;

  stopwatch_bcd #(.MIN_MAX(MM)) dut (
    .clk(clk), .rst_n(rst_n), .hsec_tick(hsec_tick),
    .start_stop_n(start_stop_n), .lap_clr_n(lap_clr_n),
    .hsec_bcd(hsec_bcd), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
    .running(running), .lap(lap), .rollover(rollover)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: state plus count as a plain number of hundredths.
  int m_st, m_t, m_lapv;
  bit m_roll;
  bit s1, s2, s3, l1, l2, l3;

  function automatic logic [23:0] to_disp(int t);
    int m, s, h;
    m = t / 6000;
    s = (t / 100) % 60;
    h = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_t = 0; m_lapv = 0; m_roll = 0;
    s1 = 1; s2 = 1; s3 = 1; l1 = 1; l2 = 1; l3 = 1;
  endtask

  // A button level seen at edge E becomes a press at edge E+2 if it was high the edge before.
  task automatic model_step(input bit ss, input bit lc, input bit tk);
    bit ps, pl, en;
    int nt;
    ps = !s2 && s3;
    pl = !l2 && l3;
    en = tk && (m_st == M_RUN || m_st == M_LAP);
    nt = en ? (m_t + 1) % MAXT : m_t;
    m_roll = en && (m_t == MAXT - 1);
    case (m_st)
      M_IDLE: if (ps) m_st = M_RUN;
      M_RUN:  if (ps) m_st = M_STOP; else if (pl) begin m_st = M_LAP; m_lapv = nt; end
      M_LAP:  if (ps) m_st = M_STOP; else if (pl) m_st = M_RUN;
      default: if (ps) m_st = M_RUN; else if (pl) begin m_st = M_IDLE; nt = 0; m_lapv = 0; end
    endcase
    m_t = nt;
    s3 = s2; s2 = s1; s1 = ss;
    l3 = l2; l2 = l1; l1 = lc;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Drive at the falling edge, step the model on the rising edge, return at the next falling edge.
  task automatic cyc(input bit ss, input bit lc, input bit tk);
    start_stop_n = ss; lap_clr_n = lc; hsec_tick = tk;
    @(posedge clk);
    model_step(ss, lc, tk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    start_stop_n = 1; lap_clr_n = 1; hsec_tick = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    string       nm;
    bit          rs, ss, lc, tk;
    int          n;
    bit          c;
    logic [23:0] d;
    bit          r, l;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string nm, bit rs, bit ss, bit lc, bit tk, int n,
                              bit c, logic [23:0] d, bit r, bit l);
    vec_t v;
    v.nm = nm; v.rs = rs; v.ss = ss; v.lc = lc; v.tk = tk;
    v.n = n; v.c = c; v.d = d; v.r = r; v.l = l;
    tbl.push_back(v);
  endfunction

  // One-cycle press followed by two released cycles so the press reaches the state.
  function automatic void press(string nm, bit ss, bit lc, bit tk, bit c,
                                logic [23:0] d, bit r, bit l);
    add(nm, 0, ss, lc, tk, 1, 0, '0, 0, 0);
    add(nm, 0, 1, 1, tk, 2, c, d, r, l);
  endfunction

  initial begin
    rst_n = 0; start_stop_n = 1; lap_clr_n = 1; hsec_tick = 0;
    model_reset();

    add("reset_state", 1, 1, 1, 0, 0, 1, 24'h000000, 0, 0);
    press("idle_lap_ignored", 1, 0, 0, 1, 24'h000000, 0, 0);
    press("start_run",        0, 1, 0, 1, 24'h000000, 1, 0);
    add("run_150", 0, 1, 1, 1, 150, 1, 24'h000150, 1, 0);

    add("rst2", 1, 1, 1, 0, 0, 0, '0, 0, 0);
    press("start2", 0, 1, 0, 0, '0, 0, 0);
    add("run_37", 0, 1, 1, 1, 37, 1, 24'h000037, 1, 0);
    press("stop_37",          0, 1, 0, 1, 24'h000037, 0, 0);
    add("stop_hold", 0, 1, 1, 1, 10, 1, 24'h000037, 0, 0);
    press("restart",          0, 1, 0, 1, 24'h000037, 1, 0);
    add("one_tick", 0, 1, 1, 1, 1, 1, 24'h000038, 1, 0);
    add("to_205", 0, 1, 1, 1, 167, 1, 24'h000205, 1, 0);
    press("lap_enter",        1, 0, 0, 1, 24'h000205, 1, 1);
    add("lap_frozen", 0, 1, 1, 1, 300, 1, 24'h000205, 1, 1);
    press("lap_exit",         1, 0, 0, 1, 24'h000505, 1, 0);

    add("rst3", 1, 1, 1, 0, 0, 0, '0, 0, 0);
    press("start3", 0, 1, 0, 0, '0, 0, 0);
    add("run_300", 0, 1, 1, 1, 300, 0, '0, 0, 0);
    press("stop_300",         0, 1, 0, 1, 24'h000300, 0, 0);
    press("clear",            1, 0, 0, 1, 24'h000000, 0, 0);
    press("start4", 0, 1, 0, 0, '0, 0, 0);
    add("run_300b", 0, 1, 1, 1, 300, 0, '0, 0, 0);
    press("stop_300b",        0, 1, 0, 1, 24'h000300, 0, 0);
    press("both_from_stop",   0, 0, 0, 1, 24'h000300, 1, 0);
    press("lap2",             1, 0, 0, 1, 24'h000300, 1, 1);
    add("lap2_run", 0, 1, 1, 1, 50, 1, 24'h000300, 1, 1);
    press("lap_to_stop",      0, 1, 0, 1, 24'h000350, 0, 0);
    press("start_tick_nocnt", 0, 1, 1, 1, 24'h000350, 1, 0);
    add("tick_351", 0, 1, 1, 1, 1, 1, 24'h000351, 1, 0);
    press("stop_tick_cnt",    0, 1, 1, 1, 24'h000354, 0, 0);

    foreach (tbl[k]) begin
      if (tbl[k].rs) do_reset();
      else for (int unsigned i = 0; i < tbl[k].n; i++) cyc(tbl[k].ss, tbl[k].lc, tbl[k].tk);
      if (tbl[k].c) begin
        chk({tbl[k].nm, ".disp"}, {8'h0, min_bcd, sec_bcd, hsec_bcd}, {8'h0, tbl[k].d});
        chk({tbl[k].nm, ".running"}, {31'h0, running}, {31'h0, tbl[k].r});
        chk({tbl[k].nm, ".lap"}, {31'h0, lap}, {31'h0, tbl[k].l});
      end
    end

    // Rollover from MM:59.99.
    do_reset();
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    for (int unsigned i = 0; i < MAXT - 1; i++) cyc(1, 1, 1);
    chk("pre_wrap.disp", {8'h0, min_bcd, sec_bcd, hsec_bcd}, 32'h00035999);
    chk("pre_wrap.rollover", {31'h0, rollover}, 32'h0);
    cyc(1, 1, 1);
    chk("wrap.disp", {8'h0, min_bcd, sec_bcd, hsec_bcd}, 32'h0);
    chk("wrap.rollover", {31'h0, rollover}, 32'h1);
    cyc(1, 1, 0);
    chk("wrap_next.rollover", {31'h0, rollover}, 32'h0);
    cyc(1, 1, 1);
    chk("post_wrap.disp", {8'h0, min_bcd, sec_bcd, hsec_bcd}, 32'h00000001);

    // Asynchronous reset in the middle of a count.
    do_reset();
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    for (int unsigned i = 0; i < 8345; i++) cyc(1, 1, 1);
    chk("pre_areset.disp", {8'h0, min_bcd, sec_bcd, hsec_bcd}, 32'h00012345);
    hsec_tick = 0;
    #2 rst_n = 0;
    #1;
    chk("areset.disp", {8'h0, min_bcd, sec_bcd, hsec_bcd}, 32'h0);
    chk("areset.running", {31'h0, running}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (4) cyc(1, 1, 1);
    chk("after_release.disp", {8'h0, min_bcd, sec_bcd, hsec_bcd}, 32'h0);
    chk("after_release.running", {31'h0, running}, 32'h0);

    // Random buttons and ticks against the model.
    do_reset();
    for (int unsigned i = 0; i < 4000; i++) begin
      logic [26:0] exp;
      cyc($urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1);
      exp = {(m_st == M_LAP) ? to_disp(m_lapv) : to_disp(m_t),
             m_st == M_RUN || m_st == M_LAP, m_st == M_LAP, m_roll};
      chk("rand", {5'h0, min_bcd, sec_bcd, hsec_bcd, running, lap, rollover}, {5'h0, exp});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
